// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, word-length codes and
// oversampling tick constants.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    localparam int unsigned OSR16  = 16;
    localparam int unsigned OSR13  = 13;
    localparam int unsigned HALF16 = 8;
    localparam int unsigned HALF13 = 7;

    // Index of the last data bit for a word-length code (5 bits -> 4 ... 8 bits -> 7).
    function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
        return 3'(wls) + 3'd4;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial input synchronizer with registered previous level and falling-edge pulse.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxd_sync,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw line through the synchronizer chain; idle level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rxd_sync = sync_q[SYNC_STAGES-1];
    assign fall     = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: frames start/data/parity/stop on the oversampling tick
// and presents each character with parity, framing and break status.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_tick,
    input  logic       OSM_SEL,
    input  logic       rxd,
    input  logic [1:0] WLS,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       SP,
    output logic       syn_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       break_det,
    output logic       busy
);

    logic rxd_sync;
    logic fall;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .rxd     (rxd),
        .rxd_sync(rxd_sync),
        .fall    (fall)
    );

    rx_state_e  state_q, state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_err_q, par_err_d;
    logic       par_bit_q, par_bit_d;
    logic       osm_q, osm_d;
    logic [1:0] wls_q, wls_d;
    logic       pen_q, pen_d;
    logic       eps_q, eps_d;
    logic       sp_q, sp_d;

    logic       syn_clr_q, syn_clr_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       parity_err_q, parity_err_d;
    logic       frame_err_q, frame_err_d;
    logic       break_det_q, break_det_d;
    logic       busy_q, busy_d;

    logic [3:0] half_last;
    logic [3:0] bit_last;
    logic       exp_par;

    // Tick count of the final tick in the half-bit / full-bit window for the frame's rate.
    assign half_last = osm_q ? 4'(HALF13 - 1) : 4'(HALF16 - 1);
    assign bit_last  = osm_q ? 4'(OSR13 - 1)  : 4'(OSR16 - 1);

    // Unused MSBs of shift_q are zero, so they do not disturb the reduction.
    assign exp_par = sp_q ? ~eps_q : (eps_q ? ^shift_q : ~^shift_q);

    // Next-state, datapath and registered-output logic for the receive FSM.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_err_d    = par_err_q;
        par_bit_d    = par_bit_q;
        osm_d        = osm_q;
        wls_d        = wls_q;
        pen_d        = pen_q;
        eps_d        = eps_q;
        sp_d         = sp_q;
        syn_clr_d    = 1'b0;
        rx_valid_d   = 1'b0;
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_det_d  = break_det_q;

        unique case (state_q)
            StIdle: begin
                // Ticks are ignored here; a tick coinciding with the edge is not counted.
                if (fall) begin
                    syn_clr_d  = 1'b1;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                    par_err_d  = 1'b0;
                    par_bit_d  = 1'b0;
                    osm_d      = OSM_SEL;
                    wls_d      = WLS;
                    pen_d      = PEN;
                    eps_d      = EPS;
                    sp_d       = SP;
                    state_d    = StStart;
                end
            end

            StStart: begin
                if (rx_tick) begin
                    if (tick_cnt_q == half_last) begin
                        tick_cnt_d = '0;
                        state_d    = rxd_sync ? StIdle : StData;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end

            StData: begin
                if (rx_tick) begin
                    if (tick_cnt_q == bit_last) begin
                        tick_cnt_d         = '0;
                        shift_d[bit_cnt_q] = rxd_sync;
                        bit_cnt_d          = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == last_bit_idx(wls_q)) begin
                            state_d = pen_q ? StParity : StStop;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end

            StParity: begin
                if (rx_tick) begin
                    if (tick_cnt_q == bit_last) begin
                        tick_cnt_d = '0;
                        par_bit_d  = rxd_sync;
                        par_err_d  = (rxd_sync != exp_par);
                        state_d    = StStop;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end

            StStop: begin
                if (rx_tick) begin
                    if (tick_cnt_q == bit_last) begin
                        tick_cnt_d   = '0;
                        rx_valid_d   = 1'b1;
                        rx_data_d    = shift_q;
                        parity_err_d = par_err_q;
                        frame_err_d  = ~rxd_sync;
                        // par_bit_q stays 0 when parity is disabled.
                        break_det_d  = (shift_q == 8'h00) && !par_bit_q && !rxd_sync;
                        state_d      = StIdle;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end

            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            par_bit_q    <= 1'b0;
            osm_q        <= 1'b0;
            wls_q        <= WLS_8;
            pen_q        <= 1'b0;
            eps_q        <= 1'b0;
            sp_q         <= 1'b0;
            syn_clr_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            par_bit_q    <= par_bit_d;
            osm_q        <= osm_d;
            wls_q        <= wls_d;
            pen_q        <= pen_d;
            eps_q        <= eps_d;
            sp_q         <= sp_d;
            syn_clr_q    <= syn_clr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_det_q  <= break_det_d;
            busy_q       <= busy_d;
        end
    end

    assign syn_clr    = syn_clr_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: a divide-by-5 tick source stands in for the
// baud/tick generators; frames are driven bit-by-bit and expected results queued.
module tb_uart_rx_core;

    localparam int unsigned DIV = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_tick;
    logic       osm_sel = 1'b0;
    logic       rxd = 1'b1;
    logic [1:0] wls = 2'b11;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sp = 1'b0;
    logic       syn_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       break_det;
    logic       busy;

    uart_rx_core #(
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_tick   (rx_tick),
        .OSM_SEL   (osm_sel),
        .rxd       (rxd),
        .WLS       (wls),
        .PEN       (pen),
        .EPS       (eps),
        .SP        (sp),
        .syn_clr   (syn_clr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .break_det (break_det),
        .busy      (busy)
    );

    always #10 clk = ~clk;  // 50 MHz

    // Tick source, phase-realigned by syn_clr.
    int unsigned div_cnt = 0;
    always @(posedge clk) begin
        if (rst || syn_clr) div_cnt <= 0;
        else                div_cnt <= (div_cnt == DIV - 1) ? 0 : div_cnt + 1;
    end
    assign rx_tick = (div_cnt == DIV - 1);

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [10:0] exp_q[$];   // {data, parity_err, frame_err, break_det}
    int unsigned last_fall_cyc = 0;
    int exp_syn = 0;
    int got_syn = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every rx_valid, checks syn_clr latency.
    always @(negedge clk) begin
        if (rx_valid) begin
            check("valid_single_cycle", 32'(prev_valid), 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rx_valid: got data %0h, expected no frame", rx_data);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                check("rx_data",    32'(rx_data),    32'(e[10:3]));
                check("parity_err", 32'(parity_err), 32'(e[2]));
                check("frame_err",  32'(frame_err),  32'(e[1]));
                check("break_det",  32'(break_det),  32'(e[0]));
            end
        end
        if (syn_clr) begin
            got_syn++;
            // Fall driven at a negedge; two sync stages plus one register stage.
            check("syn_clr_latency", cyc - last_fall_cyc, 32'd3);
        end
        prev_valid = rx_valid;
    end

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_fall();
        rxd = 1'b0;
        last_fall_cyc = cyc;
        exp_syn++;
    endtask

    task automatic send_frame(input logic osm, input logic [1:0] w, input logic p,
                              input logic e, input logic s, input logic [7:0] d,
                              input logic par, input logic stp);
        int unsigned nb;
        int unsigned bt;
        logic [7:0]  md;
        logic        xpar;
        nb = int'(w) + 5;
        bt = (osm ? 13 : 16) * DIV;
        md = d & 8'((1 << nb) - 1);
        // Even parity: bit equals XOR of data; odd: its complement; stick: ~EPS.
        xpar = s ? !e : (e ? ($countones(md) % 2 == 1) : ($countones(md) % 2 == 0));
        exp_q.push_back({md, p && (par != xpar), !stp,
                         (md == 8'h00) && (!p || !par) && !stp});
        osm_sel = osm; wls = w; pen = p; eps = e; sp = s;
        drive_fall();
        wait_clks(bt);
        for (int i = 0; i < int'(nb); i++) begin
            rxd = md[i];
            wait_clks(bt);
        end
        if (p) begin
            rxd = par;
            wait_clks(bt);
        end
        rxd = stp;
        wait_clks(bt);
        rxd = 1'b1;
        wait_clks(bt);
    endtask

    task automatic wait_drained(input string name);
        int unsigned t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rx_data"},    32'(rx_data),    32'd0);
        check({tag, "_rx_valid"},   32'(rx_valid),   32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_syn_clr"},    32'(syn_clr),    32'd0);
        check({tag, "_parity_err"}, 32'(parity_err), 32'd0);
        check({tag, "_frame_err"},  32'(frame_err),  32'd0);
        check({tag, "_break_det"},  32'(break_det),  32'd0);
    endtask

    initial begin
        int syn_before;
        wait_clks(4);
        check_idle_outputs("reset");
        rst = 1'b0;
        wait_clks(10);

        // 8N1 at 16x, 0xA5, one syn_clr.
        syn_before = got_syn;
        send_frame(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1);
        wait_drained("drain_a5");
        check("a5_syn_clr_count", 32'(got_syn - syn_before), 32'd1);

        // 7E1 at 13x, 0x35 with good then bad parity.
        send_frame(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 8'h35, 1'b0, 1'b1);
        send_frame(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 8'h35, 1'b1, 1'b1);
        wait_drained("drain_7e1");

        // 5-bit stick parity, parity bit 1.
        send_frame(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8'h1F, 1'b1, 1'b1);
        wait_drained("drain_stick");

        // False start: 30-clock low glitch at 16x.
        osm_sel = 1'b0; wls = 2'b11; pen = 1'b0;
        drive_fall();
        wait_clks(10);
        check("false_start_busy_high", 32'(busy), 32'd1);
        wait_clks(20);
        rxd = 1'b1;
        // HALF sample lands ~43 clocks after the fall.
        wait_clks(15);
        check("false_start_busy_low", 32'(busy), 32'd0);
        wait_clks(100);

        // Break: line low for 20 bit times in 8N1.
        exp_q.push_back({8'h00, 1'b0, 1'b1, 1'b1});
        drive_fall();
        wait_clks(20 * 16 * DIV);
        wait_drained("drain_break");
        check("break_no_restart_busy", 32'(busy), 32'd0);
        rxd = 1'b1;
        wait_clks(2 * 16 * DIV);

        // Reset during the data bits of 0x5A, then 0x3C.
        drive_fall();
        wait_clks(16 * DIV);
        for (int i = 0; i < 3; i++) begin
            rxd = (8'h5A >> i) & 1;
            wait_clks(16 * DIV);
        end
        rst = 1'b1;
        rxd = 1'b1;
        wait_clks(1);
        check_idle_outputs("mid_reset");
        rst = 1'b0;
        wait_clks(2 * 16 * DIV);
        check("mid_reset_queue_empty", 32'(exp_q.size()), 32'd0);
        send_frame(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1);
        wait_drained("drain_3c");

        // Randomized frames.
        for (int n = 0; n < 24; n++) begin
            send_frame(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 8'($urandom),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            wait_drained("drain_random");
        end

        wait_clks(20);
        check("syn_clr_total", 32'(got_syn), 32'(exp_syn));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
